// File: rtl/cmp_rs_sched.sv
// Reservation station for the branch comparator: holds up to SIZE ops, wakes operands
// from the CDB and offers the lowest-index ready entry to the comparator.
module cmp_rs_sched #(
  parameter int SIZE  = 8,
  parameter int TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        enq_valid_i,
  output logic                        enq_ready_o,
  input  logic [2:0]                  enq_op_i,
  input  logic [31:0]                 enq_r1_i,
  input  logic [31:0]                 enq_r2_i,
  input  logic                        enq_r1_vld_i,
  input  logic                        enq_r2_vld_i,
  input  logic [TAG_W-1:0]            enq_r1_tag_i,
  input  logic [TAG_W-1:0]            enq_r2_tag_i,
  input  logic [TAG_W-1:0]            enq_tag_i,
  input  logic                        cdb_valid_i,
  input  logic [TAG_W-1:0]            cdb_tag_i,
  input  logic [31:0]                 cdb_data_i,
  output logic                        iss_valid_o,
  input  logic                        iss_ready_i,
  output logic [2:0]                  iss_op_o,
  output logic [31:0]                 iss_r1_o,
  output logic [31:0]                 iss_r2_o,
  output logic [TAG_W-1:0]            iss_tag_o,
  output logic [$clog2(SIZE+1)-1:0]   count_o
);

  localparam int CW = $clog2(SIZE+1);
  localparam int IW = $clog2(SIZE);

  logic             busy_q   [SIZE];
  logic             busy_d   [SIZE];
  logic [2:0]       op_q     [SIZE];
  logic [2:0]       op_d     [SIZE];
  logic [31:0]      r1_q     [SIZE];
  logic [31:0]      r1_d     [SIZE];
  logic [31:0]      r2_q     [SIZE];
  logic [31:0]      r2_d     [SIZE];
  logic             r1_vld_q [SIZE];
  logic             r1_vld_d [SIZE];
  logic             r2_vld_q [SIZE];
  logic             r2_vld_d [SIZE];
  logic [TAG_W-1:0] r1_tag_q [SIZE];
  logic [TAG_W-1:0] r1_tag_d [SIZE];
  logic [TAG_W-1:0] r2_tag_q [SIZE];
  logic [TAG_W-1:0] r2_tag_d [SIZE];
  logic [TAG_W-1:0] dst_q    [SIZE];
  logic [TAG_W-1:0] dst_d    [SIZE];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic [IW-1:0]    free_idx_s;
  logic [IW-1:0]    iss_idx_s;
  logic             iss_found_s;
  logic             do_enq_s;
  logic             do_iss_s;
  logic             enq_r1_hit_s;
  logic             enq_r2_hit_s;

  // Priority pick: scanning downward leaves the lowest free and lowest ready index.
  always_comb begin
    free_idx_s  = '0;
    iss_idx_s   = '0;
    iss_found_s = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      free_idx_s  = !busy_q[i] ? IW'(i) : free_idx_s;
      iss_idx_s   = (busy_q[i] && r1_vld_q[i] && r2_vld_q[i]) ? IW'(i) : iss_idx_s;
      iss_found_s = iss_found_s | (busy_q[i] & r1_vld_q[i] & r2_vld_q[i]);
    end
  end

  assign enq_ready_o  = (count_q < CW'(SIZE));
  assign do_enq_s     = enq_valid_i & enq_ready_o;
  assign iss_valid_o  = iss_found_s;
  assign do_iss_s     = iss_found_s & iss_ready_i;
  assign enq_r1_hit_s = cdb_valid_i & ~enq_r1_vld_i & (enq_r1_tag_i == cdb_tag_i);
  assign enq_r2_hit_s = cdb_valid_i & ~enq_r2_vld_i & (enq_r2_tag_i == cdb_tag_i);
  assign iss_op_o     = iss_found_s ? op_q[iss_idx_s]  : 3'd0;
  assign iss_r1_o     = iss_found_s ? r1_q[iss_idx_s]  : 32'd0;
  assign iss_r2_o     = iss_found_s ? r2_q[iss_idx_s]  : 32'd0;
  assign iss_tag_o    = iss_found_s ? dst_q[iss_idx_s] : '0;
  assign count_o      = count_q;

  // Per-entry next state: enqueue write with CDB bypass, otherwise CDB wakeup.
  always_comb begin
    logic enq_here;
    logic iss_here;
    logic wake1;
    logic wake2;
    enq_here = 1'b0;
    iss_here = 1'b0;
    wake1    = 1'b0;
    wake2    = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      enq_here    = do_enq_s & (free_idx_s == IW'(i));
      iss_here    = do_iss_s & (iss_idx_s == IW'(i));
      wake1       = busy_q[i] & cdb_valid_i & ~r1_vld_q[i] & (r1_tag_q[i] == cdb_tag_i);
      wake2       = busy_q[i] & cdb_valid_i & ~r2_vld_q[i] & (r2_tag_q[i] == cdb_tag_i);
      busy_d[i]   = ~flush_i & ((busy_q[i] & ~iss_here) | enq_here);
      if (enq_here) begin
        op_d[i]     = enq_op_i;
        r1_d[i]     = enq_r1_hit_s ? cdb_data_i : enq_r1_i;
        r2_d[i]     = enq_r2_hit_s ? cdb_data_i : enq_r2_i;
        r1_vld_d[i] = enq_r1_vld_i | enq_r1_hit_s;
        r2_vld_d[i] = enq_r2_vld_i | enq_r2_hit_s;
        r1_tag_d[i] = enq_r1_tag_i;
        r2_tag_d[i] = enq_r2_tag_i;
        dst_d[i]    = enq_tag_i;
      end else begin
        op_d[i]     = op_q[i];
        r1_d[i]     = wake1 ? cdb_data_i : r1_q[i];
        r2_d[i]     = wake2 ? cdb_data_i : r2_q[i];
        r1_vld_d[i] = r1_vld_q[i] | wake1;
        r2_vld_d[i] = r2_vld_q[i] | wake2;
        r1_tag_d[i] = r1_tag_q[i];
        r2_tag_d[i] = r2_tag_q[i];
        dst_d[i]    = dst_q[i];
      end
    end
    count_d = flush_i ? '0 : (count_q + CW'(do_enq_s) - CW'(do_iss_s));
  end

  // State registers; reset wipes every entry including payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        busy_q[i]   <= 1'b0;
        op_q[i]     <= 3'd0;
        r1_q[i]     <= 32'd0;
        r2_q[i]     <= 32'd0;
        r1_vld_q[i] <= 1'b0;
        r2_vld_q[i] <= 1'b0;
        r1_tag_q[i] <= '0;
        r2_tag_q[i] <= '0;
        dst_q[i]    <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        busy_q[i]   <= busy_d[i];
        op_q[i]     <= op_d[i];
        r1_q[i]     <= r1_d[i];
        r2_q[i]     <= r2_d[i];
        r1_vld_q[i] <= r1_vld_d[i];
        r2_vld_q[i] <= r2_vld_d[i];
        r1_tag_q[i] <= r1_tag_d[i];
        r2_tag_q[i] <= r2_tag_d[i];
        dst_q[i]    <= dst_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule
